// File: rtl/tl_pkg.sv
// Shared definitions for the two-road intersection sequencer:
// light codes, default phase timings and the phase type.
package tl_pkg;

  // Light codes consumed by the per-road trafficlight decoders
  localparam logic [1:0] TL_RED     = 2'b00;
  localparam logic [1:0] TL_YEL     = 2'b01;
  localparam logic [1:0] TL_GRN     = 2'b10;
  localparam logic [1:0] TL_GRN_YEL = 2'b11;

  // Default phase lengths in ticks
  localparam int T_MIN_GREEN  = 10;
  localparam int T_SIDE_GREEN = 8;
  localparam int T_WARN       = 2;
  localparam int T_YELLOW     = 3;
  localparam int T_ALLRED     = 1;
  localparam int CNT_W        = 6;

  // Bit 3 marks maintenance; the eight normal phases use bits [2:0]
  typedef enum logic [3:0] {
    PH_MAIN_GREEN = 4'd0,
    PH_MAIN_WARN  = 4'd1,
    PH_MAIN_YEL   = 4'd2,
    PH_ALLRED_M   = 4'd3,
    PH_SIDE_GREEN = 4'd4,
    PH_SIDE_WARN  = 4'd5,
    PH_SIDE_YEL   = 4'd6,
    PH_ALLRED_S   = 4'd7,
    PH_MAINT      = 4'd8
  } tl_phase_t;

  // Externally visible 3-bit phase; maintenance reports as 7
  function automatic logic [2:0] phase_code(input tl_phase_t p);
    logic [3:0] raw;
    raw = p;
    return (p == PH_MAINT) ? 3'd7 : raw[2:0];
  endfunction

endpackage

// File: rtl/tl_intersection_ctrl_if.sv
// Control/status bundle between the intersection sequencer and its user.
interface tl_intersection_ctrl_if;
  logic       tick;
  logic       side_req;
  logic       maint;
  logic [1:0] main_state;
  logic [1:0] side_state;
  logic [2:0] phase;
  logic       req_pending;

  modport master (
    output tick, side_req, maint,
    input  main_state, side_state, phase, req_pending
  );

  modport slave (
    input  tick, side_req, maint,
    output main_state, side_state, phase, req_pending
  );
endinterface

// File: rtl/tl_phase_timer.sv
// Tick-gated phase timer with clear and optional saturation at limit-1.
module tl_phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clr,
  input  logic             sat,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg;
  logic             at_last;

  assign at_last = (cnt_reg == limit - ONE);
  assign done    = tick && at_last;
  assign cnt     = cnt_reg;

  // Count ticks; wrap at the last count unless saturating
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (tick) begin
      if (at_last) begin
        cnt_reg <= sat ? cnt_reg : '0;
      end else begin
        cnt_reg <= cnt_reg + ONE;
      end
    end
  end

endmodule

// File: rtl/tl_intersection_ctrl.sv
// Two-road intersection sequencer: phase FSM, side-request latch,
// maintenance blink bit and registered light-code outputs.
module tl_intersection_ctrl
  import tl_pkg::*;
#(
  parameter int P_MIN_GREEN  = T_MIN_GREEN,
  parameter int P_SIDE_GREEN = T_SIDE_GREEN,
  parameter int P_WARN       = T_WARN,
  parameter int P_YELLOW     = T_YELLOW,
  parameter int P_ALLRED     = T_ALLRED,
  parameter int P_CNT_W      = CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tl_intersection_ctrl_if.slave bus
);

  localparam logic [P_CNT_W-1:0] L_MIN_GREEN  = P_CNT_W'(P_MIN_GREEN);
  localparam logic [P_CNT_W-1:0] L_SIDE_GREEN = P_CNT_W'(P_SIDE_GREEN);
  localparam logic [P_CNT_W-1:0] L_WARN       = P_CNT_W'(P_WARN);
  localparam logic [P_CNT_W-1:0] L_YELLOW     = P_CNT_W'(P_YELLOW);
  localparam logic [P_CNT_W-1:0] L_ALLRED     = P_CNT_W'(P_ALLRED);

  tl_phase_t          state_reg, state_next;
  logic               blink_reg, blink_next;
  logic               req_reg, req_next;
  logic [1:0]         main_reg, main_next;
  logic [1:0]         side_reg, side_next;
  logic [2:0]         phase_reg;
  logic [P_CNT_W-1:0] limit;
  logic [P_CNT_W-1:0] cnt;
  logic               done;
  logic               timer_clr;
  logic               timer_sat;

  tl_phase_timer #(.CNT_W(P_CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (bus.tick),
    .clr   (timer_clr),
    .sat   (timer_sat),
    .limit (limit),
    .cnt   (cnt),
    .done  (done)
  );

  // Length of the phase currently being timed
  always_comb begin
    limit = L_ALLRED;
    case (state_reg)
      PH_MAIN_GREEN:              limit = L_MIN_GREEN;
      PH_MAIN_WARN, PH_SIDE_WARN: limit = L_WARN;
      PH_MAIN_YEL, PH_SIDE_YEL:   limit = L_YELLOW;
      PH_SIDE_GREEN:              limit = L_SIDE_GREEN;
      default:                    limit = L_ALLRED;
    endcase
  end

  // Next phase, blink bit, request latch and timer control
  always_comb begin
    state_next = state_reg;
    blink_next = 1'b0;
    if (bus.maint) begin
      state_next = PH_MAINT;
      blink_next = (state_reg == PH_MAINT) ? (blink_reg ^ bus.tick) : 1'b0;
    end else begin
      case (state_reg)
        PH_MAIN_GREEN: if (done && (req_reg || bus.side_req)) state_next = PH_MAIN_WARN;
        PH_MAIN_WARN:  if (done) state_next = PH_MAIN_YEL;
        PH_MAIN_YEL:   if (done) state_next = PH_ALLRED_M;
        PH_ALLRED_M:   if (done) state_next = PH_SIDE_GREEN;
        PH_SIDE_GREEN: if (done) state_next = PH_SIDE_WARN;
        PH_SIDE_WARN:  if (done) state_next = PH_SIDE_YEL;
        PH_SIDE_YEL:   if (done) state_next = PH_ALLRED_S;
        PH_ALLRED_S:   if (done) state_next = PH_MAIN_GREEN;
        default:       state_next = PH_ALLRED_S;
      endcase
    end

    timer_sat = (state_reg == PH_MAIN_GREEN);
    timer_clr = bus.maint || (state_reg == PH_MAINT) || (state_next != state_reg);

    // Entering side green serves the request and beats a simultaneous set
    if (bus.maint) begin
      req_next = 1'b0;
    end else if (state_next == PH_SIDE_GREEN && state_reg != PH_SIDE_GREEN) begin
      req_next = 1'b0;
    end else begin
      req_next = req_reg | bus.side_req;
    end
  end

  // Light codes for the phase being entered
  always_comb begin
    main_next = TL_RED;
    side_next = TL_RED;
    case (state_next)
      PH_MAIN_GREEN: main_next = TL_GRN;
      PH_MAIN_WARN:  main_next = TL_GRN_YEL;
      PH_MAIN_YEL:   main_next = TL_YEL;
      PH_SIDE_GREEN: side_next = TL_GRN;
      PH_SIDE_WARN:  side_next = TL_GRN_YEL;
      PH_SIDE_YEL:   side_next = TL_YEL;
      PH_MAINT: begin
        main_next = blink_next ? TL_YEL : TL_RED;
        side_next = blink_next ? TL_YEL : TL_RED;
      end
      default: begin
        main_next = TL_RED;
        side_next = TL_RED;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= PH_ALLRED_S;
      blink_reg <= 1'b0;
      req_reg   <= 1'b0;
      main_reg  <= TL_RED;
      side_reg  <= TL_RED;
      phase_reg <= 3'd7;
    end else begin
      state_reg <= state_next;
      blink_reg <= blink_next;
      req_reg   <= req_next;
      main_reg  <= main_next;
      side_reg  <= side_next;
      phase_reg <= phase_code(state_next);
    end
  end

  assign bus.main_state  = main_reg;
  assign bus.side_state  = side_reg;
  assign bus.phase       = phase_reg;
  assign bus.req_pending = req_reg;

endmodule
